// File: rtl/multicycle_ctrl_pkg.sv
// Shared encodings for the multi-cycle RV32-subset control sequencer:
// FSM states, opcodes, ALU operations and datapath mux selects.
package multicycle_ctrl_pkg;

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4,
    S_TRAP   = 3'd5
  } state_e;

  localparam logic [6:0] OP_R   = 7'b0110011;
  localparam logic [6:0] OP_I   = 7'b0010011;
  localparam logic [6:0] OP_LW  = 7'b0000011;
  localparam logic [6:0] OP_SW  = 7'b0100011;
  localparam logic [6:0] OP_BEQ = 7'b1100011;
  localparam logic [6:0] OP_JAL = 7'b1101111;

  localparam logic [2:0] ALU_AND = 3'b000;
  localparam logic [2:0] ALU_OR  = 3'b001;
  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_SUB = 3'b110;
  localparam logic [2:0] ALU_SLT = 3'b111;

  localparam logic [1:0] PC_PLUS4  = 2'b00;
  localparam logic [1:0] PC_BRANCH = 2'b01;
  localparam logic [1:0] PC_JAL    = 2'b10;

  localparam logic [1:0] WB_ALU = 2'b00;
  localparam logic [1:0] WB_MEM = 2'b01;
  localparam logic [1:0] WB_PC4 = 2'b10;

  // Only add/slt/or/and are implemented for the register and immediate ALU forms.
  function automatic logic funct3_alu_ok(input logic [2:0] funct3);
    return (funct3 == 3'b000) || (funct3 == 3'b010) ||
           (funct3 == 3'b110) || (funct3 == 3'b111);
  endfunction

  function automatic logic [2:0] funct3_to_alu(input logic [2:0] funct3, input logic sub);
    logic [2:0] op;
    case (funct3)
      3'b000:  op = sub ? ALU_SUB : ALU_ADD;
      3'b010:  op = ALU_SLT;
      3'b110:  op = ALU_OR;
      default: op = ALU_AND;
    endcase
    return op;
  endfunction

endpackage

// File: rtl/multicycle_ctrl_if.sv
// Datapath/memory strobe bundle between the control sequencer (master)
// and the datapath plus shared memory port (slave).
interface multicycle_ctrl_if;
  logic [31:0] ins;
  logic        zero;
  logic        mem_ack;
  logic        mem_req;
  logic        mem_we;
  logic        iord;
  logic        ir_write;
  logic        pc_write;
  logic [1:0]  pc_src;
  logic [2:0]  alu_op;
  logic        alu_src;
  logic        reg_write;
  logic [1:0]  wb_sel;

  modport master (
    input  ins, zero, mem_ack,
    output mem_req, mem_we, iord, ir_write, pc_write, pc_src,
           alu_op, alu_src, reg_write, wb_sel
  );

  modport slave (
    output ins, zero, mem_ack,
    input  mem_req, mem_we, iord, ir_write, pc_write, pc_src,
           alu_op, alu_src, reg_write, wb_sel
  );
endinterface

// File: rtl/multicycle_ctrl_alu_op_dec.sv
// Combinational instruction classifier: latched opcode/funct3/funct7[5]
// to the EXEC-phase ALU operation and a legality flag.
module multicycle_ctrl_alu_op_dec
  import multicycle_ctrl_pkg::*;
(
  input  logic [6:0] i_opcode,
  input  logic [2:0] i_funct3,
  input  logic       i_funct7b5,
  output logic [2:0] o_alu_op,
  output logic       o_legal
);

  always_comb begin
    o_alu_op = ALU_ADD;
    o_legal  = 1'b0;
    case (i_opcode)
      OP_R: begin
        o_alu_op = funct3_to_alu(i_funct3, i_funct7b5);
        o_legal  = funct3_alu_ok(i_funct3) && (!i_funct7b5 || (i_funct3 == 3'b000));
      end
      // Bit 30 of an I-type word is immediate data, so it never selects sub.
      OP_I: begin
        o_alu_op = funct3_to_alu(i_funct3, 1'b0);
        o_legal  = funct3_alu_ok(i_funct3);
      end
      OP_LW, OP_SW: begin
        o_alu_op = ALU_ADD;
        o_legal  = 1'b1;
      end
      OP_BEQ: begin
        o_alu_op = ALU_SUB;
        o_legal  = 1'b1;
      end
      OP_JAL: begin
        o_alu_op = ALU_AND;
        o_legal  = 1'b1;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/multicycle_ctrl.sv
// Multi-cycle FETCH/DECODE/EXEC/MEM/WB sequencer with memory-timeout and
// illegal-opcode trap plus a retired-instruction counter.
module multicycle_ctrl
  import multicycle_ctrl_pkg::*;
#(
  parameter int CNT_W       = 32,
  parameter int MEM_TIMEOUT = 255
)
(
  input  logic              clk,
  input  logic              rst_n,
  multicycle_ctrl_if.master bus,
  output logic              trap,
  output logic [CNT_W-1:0]  retired
);

  state_e           r_state;
  logic             r_run;
  logic [6:0]       r_opcode;
  logic [2:0]       r_funct3;
  logic             r_funct7b5;
  logic [15:0]      r_wait;
  logic [CNT_W-1:0] r_retired;

  logic [2:0] w_alu_op;
  logic       w_legal;
  logic       w_wait_expired;
  logic       w_unused_ins;

  logic       w_mem_req, w_mem_we, w_iord, w_ir_write, w_pc_write;
  logic [1:0] w_pc_src, w_wb_sel;
  logic [2:0] w_alu_op_out;
  logic       w_alu_src, w_reg_write;

  assign w_wait_expired = (r_wait == 16'(MEM_TIMEOUT));
  assign w_unused_ins   = ^{bus.ins[31], bus.ins[29:15], bus.ins[11:7]};

  multicycle_ctrl_alu_op_dec u_alu_op_dec (
    .i_opcode   (r_opcode),
    .i_funct3   (r_funct3),
    .i_funct7b5 (r_funct7b5),
    .o_alu_op   (w_alu_op),
    .o_legal    (w_legal)
  );

  // r_run holds everything quiet for the first cycle after reset release,
  // so mem_req only rises once the block has seen a clock edge out of reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= S_FETCH;
      r_run      <= 1'b0;
      r_opcode   <= '0;
      r_funct3   <= '0;
      r_funct7b5 <= 1'b0;
      r_wait     <= '0;
      r_retired  <= '0;
    end else begin
      r_run <= 1'b1;
      if (r_run) begin
        case (r_state)
          S_FETCH: begin
            if (bus.mem_ack) begin
              r_opcode   <= bus.ins[6:0];
              r_funct3   <= bus.ins[14:12];
              r_funct7b5 <= bus.ins[30];
              r_wait     <= '0;
              r_state    <= S_DECODE;
            end else if (w_wait_expired) begin
              r_state <= S_TRAP;
            end else begin
              r_wait <= r_wait + 16'd1;
            end
          end
          S_DECODE: r_state <= w_legal ? S_EXEC : S_TRAP;
          S_EXEC: begin
            if (r_opcode == OP_LW || r_opcode == OP_SW) begin
              r_state <= S_MEM;
            end else if (r_opcode == OP_BEQ) begin
              r_state   <= S_FETCH;
              r_retired <= r_retired + CNT_W'(1);
            end else begin
              r_state <= S_WB;
            end
          end
          S_MEM: begin
            if (bus.mem_ack) begin
              r_wait <= '0;
              if (r_opcode == OP_SW) begin
                r_state   <= S_FETCH;
                r_retired <= r_retired + CNT_W'(1);
              end else begin
                r_state <= S_WB;
              end
            end else if (w_wait_expired) begin
              r_state <= S_TRAP;
            end else begin
              r_wait <= r_wait + 16'd1;
            end
          end
          S_WB: begin
            r_state   <= S_FETCH;
            r_retired <= r_retired + CNT_W'(1);
          end
          S_TRAP:  r_state <= S_TRAP;
          default: r_state <= S_TRAP;
        endcase
      end
    end
  end

  // Strobes follow the state register and latched fields; only the fetch
  // write enables (mem_ack) and the branch pc_write (zero) look at inputs.
  always_comb begin
    w_mem_req    = 1'b0;
    w_mem_we     = 1'b0;
    w_iord       = 1'b0;
    w_ir_write   = 1'b0;
    w_pc_write   = 1'b0;
    w_pc_src     = PC_PLUS4;
    w_alu_op_out = ALU_AND;
    w_alu_src    = 1'b0;
    w_reg_write  = 1'b0;
    w_wb_sel     = WB_ALU;
    if (r_run) begin
      case (r_state)
        S_FETCH: begin
          w_mem_req  = 1'b1;
          w_ir_write = bus.mem_ack;
          w_pc_write = bus.mem_ack;
        end
        S_EXEC: begin
          case (r_opcode)
            OP_R: w_alu_op_out = w_alu_op;
            OP_I, OP_LW, OP_SW: begin
              w_alu_op_out = w_alu_op;
              w_alu_src    = 1'b1;
            end
            OP_BEQ: begin
              w_alu_op_out = w_alu_op;
              w_pc_src     = PC_BRANCH;
              w_pc_write   = bus.zero;
            end
            OP_JAL: begin
              w_pc_src   = PC_JAL;
              w_pc_write = 1'b1;
            end
            default: ;
          endcase
        end
        S_MEM: begin
          w_mem_req    = 1'b1;
          w_iord       = 1'b1;
          w_mem_we     = (r_opcode == OP_SW);
          w_alu_op_out = ALU_ADD;
          w_alu_src    = 1'b1;
        end
        S_WB: begin
          w_reg_write = 1'b1;
          if (r_opcode == OP_LW)       w_wb_sel = WB_MEM;
          else if (r_opcode == OP_JAL) w_wb_sel = WB_PC4;
          else                         w_wb_sel = WB_ALU;
        end
        default: ;
      endcase
    end
  end

  assign bus.mem_req   = w_mem_req;
  assign bus.mem_we    = w_mem_we;
  assign bus.iord      = w_iord;
  assign bus.ir_write  = w_ir_write;
  assign bus.pc_write  = w_pc_write;
  assign bus.pc_src    = w_pc_src;
  assign bus.alu_op    = w_alu_op_out;
  assign bus.alu_src   = w_alu_src;
  assign bus.reg_write = w_reg_write;
  assign bus.wb_sel    = w_wb_sel;
  assign trap          = (r_state == S_TRAP);
  assign retired       = r_retired;

endmodule
